ysyx_25030081_mc_cu: RTL and testbench

//  Multi-cycle RV32I control unit. Successor to the single-cycle combinational CU.
//  It latches the fetched instruction and decodes every RV32I base class: LUI, AUIPC,
//  JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP. It sequences

---
 rtl/ysyx_25030081_cu_pkg.sv | 56 +++++
 rtl/ysyx_25030081_cu_dec.sv | 93 +++++++++
 rtl/ysyx_25030081_mc_cu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_25030081_mc_cu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030081_cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, control codes,
// FSM states and the decoded control bundle.
package ysyx_25030081_cu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b1000;

  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef struct packed {
    logic [2:0] ext_op;
    logic [2:0] branch;     // {b_type, jal, jalr}
    logic [2:0] cmp_op;
    logic       mem_to_reg;
    logic       mem_wr;
    logic [2:0] mem_op;
    logic       alu_a_src;
    logic [1:0] alu_b_src;
    logic [3:0] alu_op;
    logic       reg_wr;     // class writes rd; the FSM qualifies it with WB and rd != 0
    logic       is_load;
    logic       is_store;
  } ctrl_t;

endpackage

// File: rtl/ysyx_25030081_cu_dec.sv
// Combinational RV32I decoder: opcode/funct fields in, control bundle and an
// illegal-encoding flag out.
module ysyx_25030081_cu_dec
  import ysyx_25030081_cu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl_o    = '0;
    illegal_o = (opcode_i[1:0] != 2'b11);

    unique case (opcode_i)
      OPC_LUI: begin
        ctrl_o.ext_op    = EXT_U;
        ctrl_o.alu_b_src = BSRC_IMM;
        ctrl_o.alu_op    = ALU_PASSB;
        ctrl_o.reg_wr    = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.ext_op    = EXT_U;
        ctrl_o.alu_a_src = 1'b1;
        ctrl_o.alu_b_src = BSRC_IMM;
        ctrl_o.reg_wr    = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.ext_op    = EXT_J;
        ctrl_o.branch    = 3'b010;
        ctrl_o.alu_a_src = 1'b1;
        ctrl_o.alu_b_src = BSRC_FOUR;
        ctrl_o.reg_wr    = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.ext_op    = EXT_I;
        ctrl_o.branch    = 3'b001;
        ctrl_o.alu_a_src = 1'b1;
        ctrl_o.alu_b_src = BSRC_FOUR;
        ctrl_o.reg_wr    = 1'b1;
        if (funct3_i != 3'b000) illegal_o = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.ext_op    = EXT_B;
        ctrl_o.branch    = 3'b100;
        ctrl_o.cmp_op    = funct3_i;
        ctrl_o.alu_b_src = BSRC_RS2;
        ctrl_o.alu_op    = ALU_SUB;
        if (funct3_i[2:1] == 2'b01) illegal_o = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.ext_op     = EXT_I;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_op     = funct3_i;
        ctrl_o.alu_b_src  = BSRC_IMM;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.is_load    = 1'b1;
        if (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) illegal_o = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.ext_op    = EXT_S;
        ctrl_o.mem_wr    = 1'b1;
        ctrl_o.mem_op    = funct3_i;
        ctrl_o.alu_b_src = BSRC_IMM;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.is_store  = 1'b1;
        if (funct3_i[2] || funct3_i == 3'b011) illegal_o = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl_o.ext_op    = EXT_I;
        ctrl_o.alu_b_src = BSRC_IMM;
        ctrl_o.alu_op    = {(funct3_i == 3'b101) && funct7_i[5], funct3_i};
        ctrl_o.reg_wr    = 1'b1;
        if (funct3_i == 3'b001 && funct7_i != F7_ZERO) illegal_o = 1'b1;
        if (funct3_i == 3'b101 && funct7_i != F7_ZERO && funct7_i != F7_ALT) illegal_o = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.alu_b_src = BSRC_RS2;
        ctrl_o.alu_op    = {funct7_i[5], funct3_i};
        ctrl_o.reg_wr    = 1'b1;
        if (!(funct7_i == F7_ZERO ||
              (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101))))
          illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_25030081_mc_cu.sv
// Multi-cycle RV32I control unit: latches the fetched instruction and sequences
// FETCH/EXEC/MEM/WB with IFU/LSU handshakes, a timeout watchdog and a sticky trap.
module ysyx_25030081_mc_cu
  import ysyx_25030081_cu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  output logic            ifu_req,
  input  logic            ifu_rdy,
  output logic            lsu_req,
  input  logic            lsu_rdy,
  output logic [2:0]      ext_op,
  output logic            reg_wr,
  output logic [2:0]      branch,
  output logic [2:0]      cmp_op,
  output logic            mem_to_reg,
  output logic            mem_wr,
  output logic [2:0]      mem_op,
  output logic            alu_a_src,
  output logic [1:0]      alu_b_src,
  output logic [3:0]      alu_op,
  output logic            pc_wr,
  output logic            illegal,
  output logic            fault,
  output logic            busy
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       ir_q, ir_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  illegal_q, illegal_d;
  logic                  fault_q, fault_d;

  ctrl_t ctrl;
  logic  dec_illegal;
  logic  dec_en;
  logic  timeout_hit;
  logic  unused_rs_fields;

  ysyx_25030081_cu_dec u_dec (
    .opcode_i  (ir_q[6:0]),
    .funct3_i  (ir_q[14:12]),
    .funct7_i  (ir_q[31:25]),
    .ctrl_o    (ctrl),
    .illegal_o (dec_illegal)
  );

  // Register-source fields feed the regfile directly, not the control unit.
  assign unused_rs_fields = ^ir_q[24:15];

  // The ready on the limiting cycle still completes the handshake.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    pc_wr     = 1'b0;
    dec_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rdy) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_EXEC: begin
        dec_en = 1'b1;
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else if (ctrl.is_load || ctrl.is_store) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dec_en  = 1'b1;
        lsu_req = 1'b1;
        mem_wr  = ctrl.mem_wr;
        if (lsu_rdy) begin
          if (ctrl.is_store) begin
            pc_wr   = 1'b1;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_WB: begin
        dec_en  = 1'b1;
        reg_wr  = ctrl.reg_wr && (ir_q[11:7] != 5'd0);
        pc_wr   = 1'b1;
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      ST_TRAP: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  assign ext_op     = dec_en ? ctrl.ext_op     : '0;
  assign branch     = dec_en ? ctrl.branch     : '0;
  assign cmp_op     = dec_en ? ctrl.cmp_op     : '0;
  assign mem_to_reg = dec_en ? ctrl.mem_to_reg : 1'b0;
  assign mem_op     = dec_en ? ctrl.mem_op     : '0;
  assign alu_a_src  = dec_en ? ctrl.alu_a_src  : 1'b0;
  assign alu_b_src  = dec_en ? ctrl.alu_b_src  : '0;
  assign alu_op     = dec_en ? ctrl.alu_op     : '0;

  assign illegal = illegal_q;
  assign fault   = fault_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_TRAP);

endmodule

// File: tb/tb_ysyx_25030081_mc_cu.sv
// Directed bench for the multi-cycle control unit: walks instructions cycle by cycle
// and compares strobes and decode fields against hand-derived values.
module tb_ysyx_25030081_mc_cu;

  localparam logic [31:0] I_ADDI    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_LW      = 32'h0000_A103; // lw x2,0(x1)
  localparam logic [31:0] I_SW      = 32'h0020_A023; // sw x2,0(x1)
  localparam logic [31:0] I_JAL     = 32'h0000_00EF; // jal x1,0
  localparam logic [31:0] I_BNE     = 32'h0020_9263; // bne x1,x2,+4 (rd field nonzero)
  localparam logic [31:0] I_ADDI_X0 = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] I_ZERO    = 32'h0000_0000;
  localparam logic [31:0] I_BAD_OP  = 32'h4000_1033; // f7=0100000 with f3=001

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic ifu_rdy = 1'b0;
  logic lsu_rdy = 1'b0;

  logic ifu_req, lsu_req, reg_wr, mem_to_reg, mem_wr, alu_a_src, pc_wr;
  logic illegal, fault, busy;
  logic [2:0] ext_op, branch, cmp_op, mem_op;
  logic [1:0] alu_b_src;
  logic [3:0] alu_op;
  logic [25:0] all_out;

  int vectors = 0;
  int miscompares = 0;
  int req_cycles;

  ysyx_25030081_mc_cu #(.XLEN(32), .TIMEOUT_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .ifu_req(ifu_req), .ifu_rdy(ifu_rdy), .lsu_req(lsu_req), .lsu_rdy(lsu_rdy),
    .ext_op(ext_op), .reg_wr(reg_wr), .branch(branch), .cmp_op(cmp_op),
    .mem_to_reg(mem_to_reg), .mem_wr(mem_wr), .mem_op(mem_op),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op),
    .pc_wr(pc_wr), .illegal(illegal), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  assign all_out = {ifu_req, lsu_req, ext_op, reg_wr, branch, cmp_op, mem_to_reg,
                    mem_wr, mem_op, alu_a_src, alu_b_src, alu_op, pc_wr, busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next mid-cycle point, drive inputs, let outputs settle.
  task automatic cyc(input logic [31:0] i, input logic f_rdy, input logic l_rdy);
    @(negedge clk);
    instr   = i;
    ifu_rdy = f_rdy;
    lsu_rdy = l_rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr = '0; ifu_rdy = 1'b0; lsu_rdy = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #2;
    check("rst_outs", all_out, 0);
    check("rst_flags", {illegal, fault}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_outs", all_out, 0);

    // addi x1,x0,5 with immediate ready
    cyc(I_ADDI, 1, 0);
    check("addi_fetch", {ifu_req, busy}, 2'b11);
    cyc(I_ZERO, 0, 0);
    check("addi_exec_dec", {ext_op, alu_b_src, alu_op}, {3'b000, 2'b01, 4'b0000});
    check("addi_exec_strb", {ifu_req, reg_wr, pc_wr}, 3'b000);
    cyc(I_ZERO, 0, 0);
    check("addi_wb", {reg_wr, pc_wr, alu_b_src}, {2'b11, 2'b01});

    // lw with lsu_rdy on the fourth MEM cycle (also the timeout boundary)
    cyc(I_LW, 1, 0);
    check("lw_fetch", {ifu_req, pc_wr}, 2'b10);
    cyc(I_ZERO, 0, 0);
    check("lw_exec", {lsu_req, mem_op, ext_op}, {1'b0, 3'b010, 3'b000});
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(I_ZERO, 0, (k == 3));
      if (lsu_req) req_cycles++;
    end
    check("lw_req_cycles", req_cycles, 4);
    check("lw_no_fault", fault, 0);
    cyc(I_ZERO, 0, 0);
    check("lw_wb", {mem_to_reg, reg_wr, pc_wr, lsu_req, mem_op}, {4'b1110, 3'b010});

    // sw: mem_wr with lsu_req, pc_wr in the ready cycle, no reg_wr
    cyc(I_SW, 1, 0);
    check("sw_fetch", ifu_req, 1);
    cyc(I_ZERO, 0, 0);
    check("sw_exec", {ext_op, mem_op, reg_wr}, {3'b010, 3'b010, 1'b0});
    cyc(I_ZERO, 0, 0);
    check("sw_mem_wait", {lsu_req, mem_wr, pc_wr, reg_wr}, 4'b1100);
    cyc(I_ZERO, 0, 1);
    check("sw_mem_done", {lsu_req, mem_wr, pc_wr, reg_wr}, 4'b1110);

    // jal x1,0
    cyc(I_JAL, 1, 0);
    check("jal_fetch", {ifu_req, pc_wr, reg_wr}, 3'b100);
    cyc(I_ZERO, 0, 0);
    check("jal_exec", {branch, alu_a_src, alu_b_src, ext_op, alu_op},
          {3'b010, 1'b1, 2'b10, 3'b100, 4'b0000});
    cyc(I_ZERO, 0, 0);
    check("jal_wb", {reg_wr, pc_wr}, 2'b11);

    // bne: compare via sub, no register write despite rd field
    cyc(I_BNE, 1, 0);
    cyc(I_ZERO, 0, 0);
    check("bne_exec", {branch, cmp_op, alu_op, ext_op, alu_b_src},
          {3'b100, 3'b001, 4'b1000, 3'b011, 2'b00});
    cyc(I_ZERO, 0, 0);
    check("bne_wb", {reg_wr, pc_wr}, 2'b01);

    // addi x0: rd = 0 suppresses reg_wr
    cyc(I_ADDI_X0, 1, 0);
    cyc(I_ZERO, 0, 0);
    cyc(I_ZERO, 0, 0);
    check("x0_wb", {reg_wr, pc_wr}, 2'b01);

    // ready on the limiting FETCH cycle wins
    for (int k = 0; k < 4; k++) begin
      cyc(I_ADDI, (k == 3), 0);
      check("to_edge_fetch", {ifu_req, fault}, 2'b10);
    end
    cyc(I_ZERO, 0, 0);
    check("to_edge_exec", {fault, busy, ifu_req, alu_b_src}, {3'b010, 2'b01});
    cyc(I_ZERO, 0, 0);
    check("to_edge_wb", pc_wr, 1);

    // four FETCH cycles without ready -> fault trap
    for (int k = 0; k < 4; k++) begin
      cyc(I_ZERO, 0, 0);
      check("to_fetch", ifu_req, 1);
    end
    cyc(I_ZERO, 0, 0);
    check("to_trap_flags", {illegal, fault}, 2'b01);
    check("to_trap_outs", all_out, 0);
    cyc(I_ADDI, 1, 0);
    check("to_trap_hold", {all_out, fault}, {26'd0, 1'b1});

    // reset clears the fault
    do_reset();
    check("rst2_flags", {illegal, fault, busy}, 0);

    // all-zero instruction is illegal
    cyc(I_ZERO, 1, 0);
    cyc(I_ZERO, 0, 0);
    cyc(I_ZERO, 0, 0);
    check("ill0_trap", {illegal, fault, busy}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      cyc(I_ADDI, 1, 0);
      check("ill0_hold", {ifu_req, pc_wr, illegal}, 3'b001);
    end

    // OP with f7=0100000 and f3=001 is illegal
    do_reset();
    check("rst3_flags", {illegal, fault}, 0);
    cyc(I_BAD_OP, 1, 0);
    cyc(I_ZERO, 0, 0);
    check("illop_exec_busy", busy, 1);
    cyc(I_ZERO, 0, 0);
    check("illop_trap", {illegal, busy, pc_wr, ifu_req}, 4'b1000);
    cyc(I_ZERO, 1, 1);
    check("illop_hold", {all_out, illegal}, {26'd0, 1'b1});

    // reset asserted mid-MEM aborts at once, then IDLE -> FETCH
    do_reset();
    cyc(I_LW, 1, 0);
    cyc(I_ZERO, 0, 0);
    cyc(I_ZERO, 0, 0);
    check("abort_mem", lsu_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_idle", {busy, ifu_req}, 2'b00);
    cyc(I_ZERO, 0, 0);
    check("abort_fetch", {busy, ifu_req, lsu_req}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
